io_uart_port: RTL and testbench
===============================

IO_UART_PORT -- requirements
Module: io_uart_port

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit; legal values are 4 to 65535.
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries; fixed at 8, with 3-bit pointers and a 4-bit count.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 ioAdrs  in  8  I/O port address from the CPU.
REQ-006 ioOut  in  16  write data from the CPU.
REQ-007 ioWe  in  1  write strobe; may stay high for more than one cycle.
REQ-008 ioIn  out  16  read data to the CPU; combinational mux on ioAdrs.
REQ-009 rxd  in  1  serial receive line; asynchronous; idle high.
REQ-010 txd  out  1  serial transmit line; idle high.
REQ-011 txBusy  out  1  high while the TX shifter is active or the FIFO is non-empty.

Function
REQ-012 Write detection: a write fires exactly once, on the cycle where ioWe=1 and the registered ioWe was 0; address and data are sampled on that cycle.
REQ-013 Port 0x00, write: ioOut[7:0] is pushed to the TX FIFO.
- If the FIFO is full on that cycle, the byte is dropped and the sticky flag txOvf is set.
- This holds even if the shifter pops an entry in the same cycle.
REQ-014 Port 0x01, read: status word.
- bit0 txEmpty, bit1 txFull, bit2 rxValid, bit3 txOvf, bit4 rxOvr, bit5 txBusy.
- bits[11:8] TX count (0-8); all other bits 0.
REQ-015 Port 0x01, write: each of txOvf (ioOut[3]) and rxOvr (ioOut[4]) is cleared when its ioOut bit is 1; other bits are ignored.
REQ-016 Port 0x02, read: {8'h00, rxData}. Port 0x02, write: clears rxValid; data is ignored.
REQ-017 Any other port: reads return 16'h0000; writes have no effect.
REQ-018 TX FSM states are IDLE, START, DATA, STOP.
- IDLE -> START when the FIFO is non-empty; the head byte is popped into the shift register on that transition.
- Each state lasts CLKS_PER_BIT cycles, counted by a 16-bit baud counter.
- DATA sends 8 bits, LSB first.
- STOP -> START directly when the FIFO is non-empty, otherwise STOP -> IDLE.
- txd: START=0, DATA=the shifted bit, STOP and IDLE=1.
REQ-019 txd is registered; the start bit appears 1 cycle after the IDLE->START decision.
REQ-020 A push into an empty FIFO while IDLE produces txd=0 no later than 2 cycles after the write edge.
REQ-021 FIFO pointers wrap modulo 8; count is exactly 0..8; txFull = (count==8); txEmpty = (count==0).
REQ-022 RX path:
- rxd passes through a 2-flop synchronizer.
- A falling edge starts a frame; the start bit is re-checked at CLKS_PER_BIT/2 and, if high, the receiver returns to idle.
- Data bits are sampled at bit centres, LSB first.
REQ-023 RX stop bit:
- Stop bit 1: rxData is loaded and rxValid is set.
- Stop bit 0 (framing error): the byte is discarded and no flag is set.
REQ-024 If rxValid is already 1 when a new byte completes, rxOvr is set and the new byte overwrites rxData.
REQ-025 A rxValid clear (port 0x02 write) and a byte completion in the same cycle: completion wins, so rxValid=1 and rxOvr is not set.

Reset
REQ-026 While rst_n=0:
- txd=1, txBusy=0.
- FIFO pointers and count = 0.
- TX and RX FSMs = IDLE; baud counters = 0.
- rxData=0, rxValid=0, txOvf=0, rxOvr=0.
- Registered ioWe = 0.
REQ-027 Reset mid-frame aborts immediately: txd=1 asynchronously, and FIFO contents are discarded.
REQ-028 After rst_n is released, the first ioWe=1 cycle counts as an edge.

Configuration
REQ-029 Macro IO_UART_RX_EN.
- Defined: the RX path of REQ-022..REQ-025 is built.
- Undefined: no RX logic; rxd is ignored; status bits 2 and 4 read 0; port 0x02 reads 0 and writes to it have no effect.

Verification
REQ-030 CLKS_PER_BIT=4; write 0x00 <= 0x00A5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; txBusy then falls.
REQ-031 ioWe held high 3 cycles with 0x00 <= 0x0041 -> exactly one byte transmitted; status bits[11:8] peak at 1.
REQ-032 Nine writes to 0x00 while the TX FSM is stalled mid-frame:
- Status shows count=8, txFull=1, txOvf=1.
- Writing 0x01 <= 0x0008 clears txOvf only.
REQ-033 (RX_EN) Drive 0x3C at 4 clks/bit -> port 0x02 reads 0x003C and rxValid=1; a second byte 0x55 without clearing -> rxOvr=1 and rxData=0x55.
REQ-034 (RX_EN) Frame with stop bit 0 -> rxValid stays 0; a 1-cycle low glitch on rxd -> no frame received.
REQ-035 Pull rst_n low during DATA of a queued 3-byte burst -> txd=1 immediately, count=0, and no further output after release.

Source files
------------

// File: rtl/io_uart_port_if.sv
// CPU-side I/O port bundle for io_uart_port: address, write data, write strobe and read data.
// The CPU drives through the master modport and the UART answers through the slave modport.
interface io_uart_port_if;
   logic [7:0]  ioAdrs;
   logic [15:0] ioOut;
   logic        ioWe;
   logic [15:0] ioIn;

   modport master (output ioAdrs, output ioOut, output ioWe, input ioIn);
   modport slave  (input ioAdrs, input ioOut, input ioWe, output ioIn);
endinterface

// File: rtl/io_uart_port.sv
// Memory-mapped UART: 8-entry TX FIFO feeding a serial shifter, plus status and RX data ports.
// The receive path is built only when the macro IO_UART_RX_EN is defined.
module io_uart_port #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   io_uart_port_if.slave    bus,
   input  logic             rxd,
   output logic             txd,
   output logic             txBusy
);

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [3:0]  FIFO_FULL = 4'(FIFO_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   logic        we_q;
   logic        write_fire;
   logic        wr_port0;
   logic        wr_port1;
   logic        wr_port2;

   logic [7:0]  fifo_mem [0:7];
   logic [2:0]  wr_ptr;
   logic [2:0]  rd_ptr;
   logic [3:0]  count;
   logic        tx_full;
   logic        tx_empty;
   logic        push;
   logic        tx_pop;
   logic        tx_ovf;

   tx_state_t   tx_state;
   logic [15:0] tx_baud;
   logic        tx_baud_done;
   logic [2:0]  tx_bit_idx;
   logic [7:0]  tx_shreg;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ovr;
   logic [15:0] status;
   logic        unused_bits;

   // A held strobe must only count once, so writes fire on the rising edge of ioWe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q <= 1'b0;
      end else begin
         we_q <= bus.ioWe;
      end
   end

   assign write_fire = bus.ioWe & ~we_q;
   assign wr_port0   = write_fire && (bus.ioAdrs == 8'h00);
   assign wr_port1   = write_fire && (bus.ioAdrs == 8'h01);
   assign wr_port2   = write_fire && (bus.ioAdrs == 8'h02);

   assign tx_full      = (count == FIFO_FULL);
   assign tx_empty     = (count == 4'd0);
   assign tx_baud_done = (tx_baud == BAUD_LAST);

   // Fullness is judged before any same-cycle pop, so a write to a full FIFO always drops.
   assign push   = wr_port0 && !tx_full;
   assign tx_pop = !tx_empty &&
                   ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_baud_done));

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= bus.ioOut[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 3'd0;
         rd_ptr <= 3'd0;
         count  <= 4'd0;
         tx_ovf <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 3'd1;
         end
         if (tx_pop) begin
            rd_ptr <= rd_ptr + 3'd1;
         end
         case ({push, tx_pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
         if (wr_port0 && tx_full) begin
            tx_ovf <= 1'b1;
         end else if (wr_port1 && bus.ioOut[3]) begin
            tx_ovf <= 1'b0;
         end
      end
   end

   // txd is registered and updated together with the state so each level lasts a full bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state   <= TX_IDLE;
         tx_baud    <= 16'd0;
         tx_bit_idx <= 3'd0;
         tx_shreg   <= 8'd0;
         txd        <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_baud <= 16'd0;
               if (tx_pop) begin
                  tx_shreg <= fifo_mem[rd_ptr];
                  tx_state <= TX_START;
                  txd      <= 1'b0;
               end else begin
                  txd <= 1'b1;
               end
            end
            TX_START: begin
               if (tx_baud_done) begin
                  tx_baud    <= 16'd0;
                  tx_bit_idx <= 3'd0;
                  tx_state   <= TX_DATA;
                  txd        <= tx_shreg[0];
               end else begin
                  tx_baud <= tx_baud + 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_baud_done) begin
                  tx_baud <= 16'd0;
                  if (tx_bit_idx == 3'd7) begin
                     tx_state <= TX_STOP;
                     txd      <= 1'b1;
                  end else begin
                     tx_bit_idx <= tx_bit_idx + 3'd1;
                     tx_shreg   <= {1'b0, tx_shreg[7:1]};
                     txd        <= tx_shreg[1];
                  end
               end else begin
                  tx_baud <= tx_baud + 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_baud_done) begin
                  tx_baud <= 16'd0;
                  if (tx_pop) begin
                     tx_shreg <= fifo_mem[rd_ptr];
                     tx_state <= TX_START;
                     txd      <= 1'b0;
                  end else begin
                     tx_state <= TX_IDLE;
                     txd      <= 1'b1;
                  end
               end else begin
                  tx_baud <= tx_baud + 16'd1;
               end
            end
            default: begin
               tx_state <= TX_IDLE;
               tx_baud  <= 16'd0;
               txd      <= 1'b1;
            end
         endcase
      end
   end

   assign txBusy = (tx_state != TX_IDLE) || !tx_empty;

`ifdef IO_UART_RX_EN
   localparam logic [15:0] BAUD_HALF = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t   rx_state;
   logic [15:0] rx_baud;
   logic [2:0]  rx_bit_idx;
   logic [7:0]  rx_shreg;
   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;

   // Completion is assigned after the CPU clear so a same-cycle new byte keeps rxValid set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RX_IDLE;
         rx_baud    <= 16'd0;
         rx_bit_idx <= 3'd0;
         rx_shreg   <= 8'd0;
         rx_data    <= 8'd0;
         rx_valid   <= 1'b0;
         rx_ovr     <= 1'b0;
      end else begin
         rx_s1   <= rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         if (wr_port2) begin
            rx_valid <= 1'b0;
         end
         if (wr_port1 && bus.ioOut[4]) begin
            rx_ovr <= 1'b0;
         end
         case (rx_state)
            RX_IDLE: begin
               rx_baud <= 16'd0;
               if (rx_prev && !rx_s2) begin
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_baud == BAUD_HALF) begin
                  rx_baud    <= 16'd0;
                  rx_bit_idx <= 3'd0;
                  rx_state   <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_baud <= rx_baud + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_baud == BAUD_LAST) begin
                  rx_baud  <= 16'd0;
                  rx_shreg <= {rx_s2, rx_shreg[7:1]};
                  if (rx_bit_idx == 3'd7) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_bit_idx <= rx_bit_idx + 3'd1;
                  end
               end else begin
                  rx_baud <= rx_baud + 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_baud == BAUD_LAST) begin
                  rx_baud  <= 16'd0;
                  rx_state <= RX_IDLE;
                  if (rx_s2) begin
                     rx_data  <= rx_shreg;
                     rx_valid <= 1'b1;
                     if (rx_valid && !wr_port2) begin
                        rx_ovr <= 1'b1;
                     end
                  end
               end else begin
                  rx_baud <= rx_baud + 16'd1;
               end
            end
            default: begin
               rx_state <= RX_IDLE;
               rx_baud  <= 16'd0;
            end
         endcase
      end
   end
`else
   assign rx_data  = 8'd0;
   assign rx_valid = 1'b0;
   assign rx_ovr   = 1'b0;
`endif

   assign status = {4'h0, count, 2'b00, txBusy, rx_ovr, tx_ovf, rx_valid, tx_full, tx_empty};

   always_comb begin
      bus.ioIn = 16'h0000;
      case (bus.ioAdrs)
         8'h01:   bus.ioIn = status;
         8'h02:   bus.ioIn = {8'h00, rx_data};
         default: bus.ioIn = 16'h0000;
      endcase
   end

   assign unused_bits = ^{bus.ioOut[15:8], rxd};

endmodule

// File: tb/tb_io_uart_port.sv
// Scoreboard bench for io_uart_port at 4 clocks per bit: expected TX bytes and register reads
// are queued by the stimulus and popped by independent monitors.
module tb_io_uart_port;
   localparam int CPB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rxd   = 1'b1;
   logic txd;
   logic txBusy;

   io_uart_port_if bus ();

   io_uart_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .rxd    (rxd),
      .txd    (txd),
      .txBusy (txBusy)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  tx_exp [$];
   logic [15:0] rd_exp [$];
   string       rd_name [$];
   logic        rd_req = 1'b0;
   logic [9:0]  a5_seq = 10'b1101001010;
   logic        mon_prev = 1'b1;
   logic        mon_abort;
   logic [8:0]  mon_frame;
   logic [7:0]  mon_exp;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] adrs, input logic [15:0] data, input int hold);
      @(posedge clk);
      #1;
      bus.ioAdrs = adrs;
      bus.ioOut  = data;
      bus.ioWe   = 1'b1;
      repeat (hold) @(posedge clk);
      #1 bus.ioWe = 1'b0;
   endtask

   task automatic readExpect(input logic [7:0] adrs, input logic [15:0] expected, input string name);
      @(posedge clk);
      #1;
      bus.ioAdrs = adrs;
      rd_exp.push_back(expected);
      rd_name.push_back(name);
      rd_req = 1'b1;
      @(negedge clk);
      #1 rd_req = 1'b0;
   endtask

   task automatic waitTxIdle(input int budget, input string name);
      int n;
      n = 0;
      while (txBusy === 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {15'd0, txBusy}, 16'd0);
   endtask

   task automatic sendRx(input logic [7:0] data, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, data, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 rxd = frame[i];
         repeat (CPB - 1) @(posedge clk);
      end
      @(posedge clk);
      #1 rxd = 1'b1;
      repeat (8) @(posedge clk);
   endtask

   // Register-read monitor
   always @(negedge clk) begin
      if (rd_req && rd_exp.size() > 0) begin
         checkOutput(rd_name.pop_front(), bus.ioIn, rd_exp.pop_front());
      end
   end

   // Serial decoder on txd: samples bit centres and compares {stop, data} with the queue
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_prev = 1'b1;
         end else begin
            if (mon_prev && !txd) begin
               mon_abort = 1'b0;
               mon_frame = '0;
               for (int k = 0; k < 9; k++) begin
                  for (int j = 0; j < ((k == 0) ? 5 : 4); j++) begin
                     @(negedge clk);
                     if (!rst_n) mon_abort = 1'b1;
                  end
                  mon_frame[k] = txd;
               end
               if (!mon_abort) begin
                  if (tx_exp.size() == 0) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL tx_frame: got 0x%03h, expected no frame", mon_frame);
                  end else begin
                     mon_exp = tx_exp.pop_front();
                     checkOutput("tx_frame", {7'd0, mon_frame}, {7'd0, 1'b1, mon_exp});
                  end
               end
            end
            mon_prev = txd;
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bus.ioAdrs = 8'h00;
      bus.ioOut  = 16'h0077;
      bus.ioWe   = 1'b1;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_txd", {15'd0, txd}, 16'd1);
      checkOutput("reset_busy", {15'd0, txBusy}, 16'd0);

      $display("[TB] strobe held through reset release");
      tx_exp.push_back(8'h77);
      rst_n = 1'b1;
      @(posedge clk);
      #1 bus.ioWe = 1'b0;
      waitTxIdle(200, "first_we_after_reset");
      readExpect(8'h01, 16'h0001, "status_idle");

      $display("[TB] single byte 0xA5 waveform");
      tx_exp.push_back(8'hA5);
      applyStimulus(8'h00, 16'h00A5, 1);
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checkOutput($sformatf("txd_level%0d", i / 4), {15'd0, txd}, {15'd0, a5_seq[i / 4]});
      end
      @(negedge clk);
      checkOutput("busy_after_a5", {15'd0, txBusy}, 16'd0);

      $display("[TB] held strobe pushes once");
      tx_exp.push_back(8'h41);
      applyStimulus(8'h00, 16'h0041, 3);
      tx_exp.push_back(8'h42);
      applyStimulus(8'h00, 16'h0042, 3);
      readExpect(8'h01, 16'h0120, "count_one_while_busy");
      waitTxIdle(300, "idle_after_41_42");
      readExpect(8'h01, 16'h0001, "status_after_41_42");

      $display("[TB] FIFO fill and overflow");
      tx_exp.push_back(8'h11);
      applyStimulus(8'h00, 16'h0011, 1);
      for (int i = 0; i < 9; i++) begin
         if (i < 8) tx_exp.push_back(8'(8'h20 + i));
         applyStimulus(8'h00, 16'(16'h0020 + i), 1);
      end
      readExpect(8'h01, 16'h082A, "fifo_full_ovf");
      applyStimulus(8'h01, 16'h0008, 1);
      readExpect(8'h01, 16'h0822, "ovf_cleared_only");
      waitTxIdle(1000, "idle_after_burst");
      readExpect(8'h01, 16'h0001, "status_drained");

      $display("[TB] unmapped ports");
      readExpect(8'h00, 16'h0000, "port0_read");
      readExpect(8'h05, 16'h0000, "port5_read");
      applyStimulus(8'h07, 16'h00FF, 1);
      readExpect(8'h01, 16'h0001, "status_after_port7_write");

`ifdef IO_UART_RX_EN
      $display("[TB] receive path");
      sendRx(8'h3C, 1'b1);
      readExpect(8'h02, 16'h003C, "rx_data_3c");
      readExpect(8'h01, 16'h0005, "rx_valid_set");
      sendRx(8'h55, 1'b1);
      readExpect(8'h02, 16'h0055, "rx_data_55");
      readExpect(8'h01, 16'h0015, "rx_ovr_set");
      applyStimulus(8'h01, 16'h0010, 1);
      readExpect(8'h01, 16'h0005, "rx_ovr_cleared");
      applyStimulus(8'h02, 16'h0000, 1);
      readExpect(8'h01, 16'h0001, "rx_valid_cleared");
      sendRx(8'hAA, 1'b0);
      readExpect(8'h01, 16'h0001, "framing_discard");
      @(posedge clk);
      #1 rxd = 1'b0;
      @(posedge clk);
      #1 rxd = 1'b1;
      repeat (60) @(posedge clk);
      readExpect(8'h01, 16'h0001, "glitch_ignored");
`else
      $display("[TB] receive path disabled");
      sendRx(8'h3C, 1'b1);
      readExpect(8'h02, 16'h0000, "rx_port_disabled");
      readExpect(8'h01, 16'h0001, "rx_status_disabled");
`endif

      $display("[TB] reset during a queued burst");
      applyStimulus(8'h00, 16'h00F0, 1);
      applyStimulus(8'h00, 16'h0033, 1);
      applyStimulus(8'h00, 16'h0066, 1);
      repeat (6) @(posedge clk);
      #2;
      checkOutput("txd_before_reset", {15'd0, txd}, 16'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("txd_async_reset", {15'd0, txd}, 16'd1);
      checkOutput("busy_async_reset", {15'd0, txBusy}, 16'd0);
      readExpect(8'h01, 16'h0001, "status_in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (120) @(negedge clk);
      checkOutput("no_output_after_release", {15'd0, txBusy}, 16'd0);
      readExpect(8'h01, 16'h0001, "status_after_release");

      tx_exp.push_back(8'h5A);
      applyStimulus(8'h00, 16'h005A, 1);
      waitTxIdle(200, "idle_after_5a");
      repeat (10) @(negedge clk);
      checkOutput("tx_queue_drained", 16'(tx_exp.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
